// File: rtl/seg_disp_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package seg_disp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  // Value parked on the display bus whenever nothing is being shown.
  localparam logic [15:0] BLANK = 16'h0000;

endpackage

// File: rtl/seg_disp_sched_rr_pick.sv
// Round-robin priority picker: first asserted req at ptr, ptr+1, ... wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; valid=0 when req is all zero.
module seg_disp_sched_rr_pick #(
  parameter int N = 4,
  localparam int SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             valid
);

  // Scan from farthest to nearest offset so the nearest requester is written last and wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid  = 1'b1;
        winner = SRC_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-slices the 4-digit display between N_SRC requesters round-robin, with alert preemption.
// Latency: 1 cycle from req/alert/data to registered grant and display outputs.
// Backpressure: none; a requester holds its req level and is served when the rotation reaches it.
module seg_disp_sched
  import seg_disp_sched_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int HOLD  = 50000000,
  parameter int CNT_W = 26,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      req,
  input  logic [16*N_SRC-1:0]   data,
  input  logic                  alert,
  input  logic [15:0]           alert_data,
  output logic [15:0]           disp_num,
  output logic                  disp_blank,
  output logic [N_SRC-1:0]      grant,
  output logic [SRC_W-1:0]      cur_src,
  output logic                  slot_done
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SRC_W-1:0]   ptr, ptr_n;
  logic [15:0]        num_n;
  logic               blank_n, done_n;
  logic [N_SRC-1:0]   grant_n;
  logic [SRC_W-1:0]   src_n;

  logic [SRC_W-1:0]   next_src;
  logic [SRC_W-1:0]   pick_ptr;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               timeout;

  // When a slot ends, the rotation resumes just after the source that owned it.
  assign next_src = (cur_src == SRC_W'(N_SRC - 1)) ? '0 : cur_src + 1'b1;
  assign pick_ptr = (state == ST_SHOW) ? next_src : ptr;
  assign timeout  = (cnt == CNT_W'(HOLD - 1));

  seg_disp_sched_rr_pick #(.N(N_SRC)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // Next-state and next-output decode; alert overrides every state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    num_n   = disp_num;
    blank_n = disp_blank;
    grant_n = grant;
    src_n   = cur_src;
    done_n  = 1'b0;
    if (alert) begin
      state_n = ST_ALERT;
      grant_n = '0;
      blank_n = 1'b0;
      num_n   = alert_data;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state_n           = ST_SHOW;
            grant_n           = '0;
            grant_n[pick_idx] = 1'b1;
            src_n             = pick_idx;
            cnt_n             = '0;
            blank_n           = 1'b0;
            num_n             = data[16*int'(pick_idx) +: 16];
          end else begin
            grant_n = '0;
            blank_n = 1'b1;
            num_n   = BLANK;
          end
        end
        ST_SHOW: begin
          if (timeout || !req[cur_src]) begin
            // Timeout wins over a simultaneous req drop, so slot_done follows timeout only.
            done_n = timeout;
            ptr_n  = next_src;
            if (pick_vld) begin
              grant_n           = '0;
              grant_n[pick_idx] = 1'b1;
              src_n             = pick_idx;
              cnt_n             = '0;
              blank_n           = 1'b0;
              num_n             = data[16*int'(pick_idx) +: 16];
            end else begin
              state_n = ST_IDLE;
              grant_n = '0;
              blank_n = 1'b1;
              num_n   = BLANK;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
            num_n = data[16*int'(cur_src) +: 16];
          end
        end
        ST_ALERT: begin
          // Always pass through IDLE so arbitration restarts cleanly from ptr.
          state_n = ST_IDLE;
          grant_n = '0;
          blank_n = 1'b1;
          num_n   = BLANK;
          cnt_n   = '0;
        end
        default: begin
          state_n = ST_IDLE;
          grant_n = '0;
          blank_n = 1'b1;
          num_n   = BLANK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      disp_num   <= BLANK;
      disp_blank <= 1'b1;
      grant      <= '0;
      cur_src    <= '0;
      slot_done  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      disp_num   <= num_n;
      disp_blank <= blank_n;
      grant      <= grant_n;
      cur_src    <= src_n;
      slot_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed scenarios with literal expectations plus randomized traffic.
// A slot-level behavioural model is checked against the DUT on every falling edge.
module tb_seg_disp_sched;

  localparam int N     = 4;
  localparam int HOLD  = 4;
  localparam int CNT_W = 3;
  localparam int SW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] data = '0;
  logic            alert = 1'b0;
  logic [15:0]     alert_data = '0;
  logic [15:0]     disp_num;
  logic            disp_blank;
  logic [N-1:0]    grant;
  logic [SW-1:0]   cur_src;
  logic            slot_done;

  int checks = 0;
  int errors = 0;

  seg_disp_sched #(.N_SRC(N), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .alert      (alert),
    .alert_data (alert_data),
    .disp_num   (disp_num),
    .disp_blank (disp_blank),
    .grant      (grant),
    .cur_src    (cur_src),
    .slot_done  (slot_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = nobody on display, 1 = a source owns a slot, 2 = alert showing.
  int           m_mode, m_owner, m_age, m_ptr;
  logic [15:0]  e_num;
  logic         e_blank, e_done;
  logic [N-1:0] e_grant;
  int           e_src;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [15:0] word_of(input logic [16*N-1:0] d, input int i);
    return d[16*i +: 16];
  endfunction

  task automatic give_slot(input int w);
    m_mode  = 1;
    m_owner = w;
    m_age   = 0;
    e_grant = N'(1) << w;
    e_src   = w;
    e_blank = 1'b0;
    e_num   = word_of(data, w);
  endtask

  task automatic go_dark();
    m_mode  = 0;
    e_grant = '0;
    e_blank = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_owner = 0; m_age = 0; m_ptr = 0;
      e_num = 16'h0000; e_blank = 1'b1; e_done = 1'b0; e_grant = '0; e_src = 0;
    end else begin
      int w;
      e_done = 1'b0;
      if (alert) begin
        m_mode  = 2;
        m_age   = 0;
        e_grant = '0;
        e_blank = 1'b0;
        e_num   = alert_data;
      end else if (m_mode == 2) begin
        go_dark();
      end else if (m_mode == 0) begin
        w = first_from(req, m_ptr);
        if (w >= 0) give_slot(w); else go_dark();
      end else begin
        if (m_age == HOLD - 1 || !req[m_owner]) begin
          e_done = (m_age == HOLD - 1);
          m_ptr  = (m_owner + 1) % N;
          w = first_from(req, m_ptr);
          if (w >= 0) give_slot(w); else go_dark();
        end else begin
          m_age++;
          e_num = word_of(data, m_owner);
        end
      end
    end
  end

  // Single compare process: DUT vs model every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant",      32'(grant),      32'(e_grant));
      chk("disp_blank", 32'(disp_blank), 32'(e_blank));
      chk("slot_done",  32'(slot_done),  32'(e_done));
      chk("cur_src",    32'(cur_src),    32'(e_src));
      if (!e_blank) chk("disp_num", 32'(disp_num), 32'(e_num));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_rst(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_blank", 32'(disp_blank), 32'd1);
    chk("rst_grant", 32'(grant),      32'd0);
    chk("rst_num",   32'(disp_num),   32'h0000);
    chk("rst_done",  32'(slot_done),  32'd0);
    chk("rst_src",   32'(cur_src),    32'd0);

    // Two requesters alternate
    data = {16'h4444, 16'h2222, 16'h3333, 16'h1111};
    release_rst(4'b0101);
    step(1);
    chk("rr_g0",     32'(grant),    32'b0001);
    chk("rr_num0",   32'(disp_num), 32'h1111);
    step(3);
    chk("rr_g0_end", 32'(grant),     32'b0001);
    chk("rr_nodone", 32'(slot_done), 32'd0);
    step(1);
    chk("rr_g2",      32'(grant),     32'b0100);
    chk("rr_done1",   32'(slot_done), 32'd1);
    chk("rr_num2",    32'(disp_num),  32'h2222);
    chk("model_g2",   32'(e_grant),   32'b0100);
    step(1);
    chk("rr_pulse",   32'(slot_done), 32'd0);
    step(3);
    chk("rr_back_g0", 32'(grant),     32'b0001);
    chk("rr_done2",   32'(slot_done), 32'd1);

    // Asynchronous reset mid-slot clears outputs without a clock edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_blank", 32'(disp_blank), 32'd1);
    chk("arst_grant", 32'(grant),      32'd0);
    chk("arst_num",   32'(disp_num),   32'h0000);

    // Sole requester keeps re-winning; display tracks its data
    data[63:48] = 16'h5555;
    release_rst(4'b1000);
    step(1);
    chk("solo_g",    32'(grant),    32'b1000);
    chk("solo_num",  32'(disp_num), 32'h5555);
    data[63:48] = 16'hABCD;
    step(1);
    chk("solo_live", 32'(disp_num), 32'hABCD);
    step(3);
    chk("solo_done1", 32'(slot_done), 32'd1);
    chk("solo_keep",  32'(grant),     32'b1000);
    step(4);
    chk("solo_done2", 32'(slot_done), 32'd1);

    // Granted req drops early: move on without slot_done
    pulse_rst();
    release_rst(4'b1010);
    step(1);
    chk("drop_g1", 32'(grant), 32'b0010);
    step(1);
    req = 4'b1000;
    step(1);
    chk("drop_g3",   32'(grant),     32'b1000);
    chk("drop_nodn", 32'(slot_done), 32'd0);
    chk("drop_src",  32'(cur_src),   32'd3);

    // Alert preemption, then a fresh full slot
    alert = 1'b1;
    alert_data = 16'hDEAD;
    step(1);
    chk("al_grant", 32'(grant),      32'd0);
    chk("al_num",   32'(disp_num),   32'hDEAD);
    chk("al_blank", 32'(disp_blank), 32'd0);
    step(2);
    alert = 1'b0;
    step(1);
    chk("al_idle", 32'(disp_blank), 32'd1);
    step(1);
    chk("al_resume",  32'(grant),     32'b1000);
    step(3);
    chk("al_full",    32'(grant),     32'b1000);
    chk("al_nodone",  32'(slot_done), 32'd0);

    // Every request vanishes exactly at timeout
    req = 4'b0000;
    step(1);
    chk("to_done",  32'(slot_done),  32'd1);
    chk("to_grant", 32'(grant),      32'd0);
    chk("to_blank", 32'(disp_blank), 32'd1);
    step(1);
    chk("to_pulse", 32'(slot_done), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      if ($urandom_range(0, 40) == 0) alert = ~alert;
      if ($urandom_range(0, 2) == 0) data = {$urandom, $urandom};
      alert_data = 16'($urandom);
    end
    alert = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
- Time-slicing scheduler that shares the single 4-digit seven-segment display between N_SRC requesters.
- Grants the display round-robin, holding each granted source for HOLD cycles.
- A high-priority alert input preempts the rotation.
- Outputs drive the display multiplexer's 16-bit hex input plus a blank control; sits between system status producers and the display driver.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- HOLD, 50000000, clk cycles each source stays on the display (>= 2).
- CNT_W, 26, width of the hold counter; must satisfy 2^CNT_W > HOLD.
- SRC_W, $clog2(N_SRC), width of the source index (localparam).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req  in  N_SRC  per-source display request (level).
- data  in  16*N_SRC  source i value at data[16*i +: 16], 4 hex nibbles.
- alert  in  1  preempt request (level).
- alert_data  in  16  value shown while alert is serviced.
- disp_num  out  16  value to the display multiplexer (registered).
- disp_blank  out  1  1 = display must be blanked (registered).
- grant  out  N_SRC  one-hot current owner; 0 when idle or in alert.
- cur_src  out  SRC_W  index of the last/current granted source.
- slot_done  out  1  one-cycle pulse when a slot expires by timeout.

Behaviour:
- Reset (async, immediate): state=IDLE, disp_num=16'h0000, disp_blank=1, grant=0, cur_src=0, slot_done=0, hold counter=0, rr pointer=0.
- States: IDLE, SHOW, ALERT. Alert has priority over all other transitions in every state.
- Arbitration function: first asserted req at index ptr, ptr+1, ..., wrapping mod N_SRC; "none" if req==0.
- IDLE:
  - alert=1 -> ALERT.
  - Else if any req -> SHOW with grant=onehot(winner), cur_src=winner, counter=0, disp_blank=0, all taking effect on the next edge (1-cycle latency req->grant).
  - Else stay; disp_blank=1.
- SHOW:
  - Every cycle disp_num <= data[16*cur_src +: 16], so a live value change appears 1 cycle later. Counter increments.
  - Timeout (counter==HOLD-1):
    - Assert slot_done for 1 cycle; ptr <= cur_src+1 mod N_SRC.
    - Re-arbitrate from the new ptr. A winner (may be the same source if it is the only requester) gets a fresh slot with counter=0. With no winner -> IDLE, grant=0, disp_blank=1.
  - Granted req drops before timeout: end the slot on the next edge with no slot_done; ptr <= cur_src+1; re-arbitrate as above.
  - Simultaneous timeout and req drop: treat as timeout (slot_done asserted).
- ALERT:
  - grant=0, disp_blank=0, disp_num <= alert_data every cycle; counter held at 0.
  - ptr unchanged.
  - On alert falling: go to IDLE, then arbitrate normally. The preempted source, if still requesting and first from ptr, restarts a full slot.
- Wrap-around: ptr and cur_src wrap from N_SRC-1 to 0; counter never exceeds HOLD-1.
- grant is always one-hot or zero; grant[cur_src]==1 whenever state==SHOW.

Decomposition:
- Shared package: state encoding (IDLE/SHOW/ALERT) and a BLANK value constant 16'h0000.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (inputs req and ptr; outputs winner index and valid), reusable by other arbiters.

Test Plan (HOLD=4, N_SRC=4):
- Reset with req=4'b0000 -> disp_blank=1, grant=0, disp_num=0; asserting rst mid-SHOW clears outputs without waiting for a clk edge.
- req=4'b0101, data0=16'h1111, data2=16'h2222 -> grant 0001 for 4 cycles (disp_num=1111), slot_done pulse, then grant 0100 for 4 cycles (2222), then back to 0001.
- Only req[3]=1 -> grant 1000 continuously; slot_done pulses every 4 cycles; disp_num tracks data3 with 1-cycle lag.
- During src1 slot at counter=1, drop req[1] with req=4'b1010 -> next edge grant=1000, no slot_done.
- Alert=1 mid-slot with alert_data=16'hDEAD -> next edge grant=0, disp_num=DEAD, disp_blank=0. Alert=0 -> IDLE, then the preempted source receives a fresh 4-cycle slot.
- All req drop at timeout -> slot_done=1, state IDLE, disp_blank=1 on the following edge.
